// File: rtl/cell_probe_pkg.sv
// Shared definitions for the NAND2 cell probe sequencer: FSM states,
// vector count and the reference truth table.
package cell_probe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_REPORT,
        ST_DONE
    } state_t;

    localparam int NUM_VECTORS = 4;

    // Reference output of the cell under test for input vector {a,b}.
    function automatic logic expected_y(input logic [1:0] vec);
        return ~(vec[1] & vec[0]);
    endfunction

endpackage

// File: rtl/cell_probe_seq_sync2.sv
// Two-flop synchronizer for a single asynchronous input; clears to 0 on reset.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/cell_probe_seq.sv
// Drives a NAND2 cell through all four input vectors, checks each synchronized
// output against the truth table and shifts the per-vector verdicts out serially.
module cell_probe_seq
    import cell_probe_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4  // legal 2..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] result,
    output logic       ser_data,
    output logic       ser_valid
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [1:0] LAST_VEC    = 2'(NUM_VECTORS - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_settle_cnt;
    logic [7:0]  w_settle_cnt_next;
    logic [1:0]  r_vec;
    logic [1:0]  w_vec_next;
    logic [1:0]  r_rpt_cnt;
    logic [1:0]  w_rpt_cnt_next;
    logic [3:0]  r_result;
    logic [3:0]  w_result_next;
    logic        r_pass;
    logic        w_pass_next;
    logic        r_busy;
    logic        w_busy_next;
    logic        r_done;
    logic        w_done_next;
    logic        r_ser_data;
    logic        w_ser_data_next;
    logic        r_ser_valid;
    logic        w_ser_valid_next;
    logic        w_sync_y;
    logic        w_match;
    logic        w_accept;

    sync2 u_sync_y (
        .clk (clk),
        .rst (rst),
        .d   (dut_y),
        .q   (w_sync_y)
    );

    assign w_match  = (w_sync_y == expected_y(r_vec));
    assign w_accept = (r_state == ST_IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_next = ST_DRIVE;
            ST_DRIVE:  w_state_next = ST_SETTLE;
            ST_SETTLE: if (r_settle_cnt == SETTLE_LAST) w_state_next = ST_SAMPLE;
            ST_SAMPLE: w_state_next = (r_vec == LAST_VEC) ? ST_REPORT : ST_DRIVE;
            ST_REPORT: if (r_rpt_cnt == 2'd3) w_state_next = ST_DONE;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Next values of every registered output, derived from the upcoming state
    // so that each output is a flop and still lines up with its state.
    always_comb begin
        w_settle_cnt_next = (r_state == ST_SETTLE) ? r_settle_cnt + 8'd1 : 8'd0;
        w_rpt_cnt_next    = (r_state == ST_REPORT) ? r_rpt_cnt + 2'd1 : 2'd0;
        w_vec_next        = r_vec;
        w_result_next     = r_result;
        w_pass_next       = r_pass;

        if (w_accept) begin
            w_vec_next    = 2'd0;
            w_result_next = 4'd0;
            w_pass_next   = 1'b0;
        end

        if (r_state == ST_SAMPLE) begin
            w_result_next[r_vec] = w_match;
            if (w_state_next == ST_DRIVE) begin
                w_vec_next = r_vec + 2'd1;
            end
        end

        if (w_state_next == ST_DONE) begin
            w_pass_next = &w_result_next;
        end

        w_busy_next      = (w_state_next != ST_IDLE);
        w_done_next      = (w_state_next == ST_DONE);
        w_ser_valid_next = (w_state_next == ST_REPORT);
        w_ser_data_next  = w_ser_valid_next ? w_result_next[w_rpt_cnt_next] : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_settle_cnt <= 8'd0;
            r_rpt_cnt    <= 2'd0;
            r_vec        <= 2'd0;
            r_result     <= 4'd0;
            r_pass       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_ser_data   <= 1'b0;
            r_ser_valid  <= 1'b0;
        end else begin
            r_settle_cnt <= w_settle_cnt_next;
            r_rpt_cnt    <= w_rpt_cnt_next;
            r_vec        <= w_vec_next;
            r_result     <= w_result_next;
            r_pass       <= w_pass_next;
            r_busy       <= w_busy_next;
            r_done       <= w_done_next;
            r_ser_data   <= w_ser_data_next;
            r_ser_valid  <= w_ser_valid_next;
        end
    end

    // The vector index register doubles as the cell drive, so the pins hold
    // vector 11 after a run.
    assign dut_a     = r_vec[1];
    assign dut_b     = r_vec[0];
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign result    = r_result;
    assign ser_data  = r_ser_data;
    assign ser_valid = r_ser_valid;

endmodule

// File: tb/tb_cell_probe_seq.sv
// Directed bench for cell_probe_seq: two instances (S=4 and S=2) each driven
// by a behavioural NAND model that can be delayed or stuck.
module tb_cell_probe_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start4, start2;
    logic       y4, y2;
    logic       a4, b4, busy4, done4, pass4, sd4, sv4;
    logic       a2, b2, busy2, done2, pass2, sd2, sv2;
    logic [3:0] res4, res2;

    // mode: 0 = NAND with dly-cycle delay, 1 = stuck at 1, 2 = stuck at 0
    int mode4 = 0, dly4 = 1, mode2 = 0, dly2 = 0;
    logic [3:0] hist4, hist2;

    int checks = 0;
    int errors = 0;

    cell_probe_seq #(.SETTLE_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .dut_a(a4), .dut_b(b4), .dut_y(y4),
        .busy(busy4), .done(done4), .pass(pass4), .result(res4),
        .ser_data(sd4), .ser_valid(sv4)
    );

    cell_probe_seq #(.SETTLE_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .dut_a(a2), .dut_b(b2), .dut_y(y2),
        .busy(busy2), .done(done2), .pass(pass2), .result(res2),
        .ser_data(sd2), .ser_valid(sv2)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist4 <= 4'd0;
            hist2 <= 4'd0;
        end else begin
            hist4 <= {hist4[2:0], ~(a4 & b4)};
            hist2 <= {hist2[2:0], ~(a2 & b2)};
        end
    end

    function automatic logic model_y(input int mode, input int dly, input logic a,
                                     input logic b, input logic [3:0] hist);
        if (mode == 1) return 1'b1;
        if (mode == 2) return 1'b0;
        if (dly == 0) return ~(a & b);
        return hist[dly-1];
    endfunction

    always_comb y4 = model_y(mode4, dly4, a4, b4, hist4);
    always_comb y2 = model_y(mode2, dly2, a2, b2, hist2);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // One full probe run on the chosen instance; edge 0 is the edge that
    // sees start high. Samples are taken on the falling edge after edge k.
    task automatic run_probe(input string name, input int inst, input int s,
                             input bit mid_start, input logic [3:0] exp_res);
        logic [3:0] ser = 4'd0;
        logic [3:0] res_done = 4'hx;
        logic       pass_done = 1'bx;
        logic       sv, sd, dn, bz, ps;
        logic [3:0] rs;
        int nser = 0, first_sv = -1, done_k = -1, ndone = 0, fall_k = -1;
        int l = 4 * (s + 2);

        @(negedge clk);
        if (inst == 2) start2 = 1'b1; else start4 = 1'b1;
        rst = 1'b0;
        for (int k = 0; k < 100 && fall_k < 0; k++) begin
            @(negedge clk);
            sv = (inst == 2) ? sv2 : sv4;
            sd = (inst == 2) ? sd2 : sd4;
            dn = (inst == 2) ? done2 : done4;
            bz = (inst == 2) ? busy2 : busy4;
            ps = (inst == 2) ? pass2 : pass4;
            rs = (inst == 2) ? res2 : res4;
            if (sv) begin
                if (first_sv < 0) first_sv = k;
                if (nser < 4) ser[nser] = sd;
                nser++;
            end
            if (dn) begin
                ndone++;
                done_k    = k;
                res_done  = rs;
                pass_done = ps;
            end
            if (!bz) fall_k = k;
            if (k == 0 || k == 4) begin
                start2 = 1'b0;
                start4 = 1'b0;
            end
            if (mid_start && k == 3) begin
                if (inst == 2) start2 = 1'b1; else start4 = 1'b1;
            end
        end
        check({name, " result"}, 32'(res_done), 32'(exp_res));
        check({name, " pass"}, 32'(pass_done), 32'(&exp_res));
        check({name, " serial"}, 32'(ser), 32'(exp_res));
        check({name, " ser_count"}, 32'(nser), 32'd4);
        check({name, " ser_first"}, 32'(first_sv), 32'(l));
        check({name, " done_edge"}, 32'(done_k), 32'(l + 4));
        check({name, " done_count"}, 32'(ndone), 32'd1);
        check({name, " busy_fall"}, 32'(fall_k), 32'(l + 5));
    endtask

    initial begin
        rst    = 1'b1;
        start4 = 1'b0;
        start2 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst busy", 32'(busy4), 32'd0);
        check("rst done", 32'(done4), 32'd0);
        check("rst pass", 32'(pass4), 32'd0);
        check("rst result", 32'(res4), 32'd0);
        check("rst drive", 32'({a4, b4}), 32'd0);
        check("rst ser", 32'({sv4, sd4}), 32'd0);
        rst = 1'b0;

        mode4 = 0; dly4 = 1;
        run_probe("ideal_s4", 4, 4, 1'b0, 4'b1111);
        check("hold drive", 32'({a4, b4}), 32'd3);
        check("hold result", 32'(res4), 32'hF);

        mode4 = 1;
        run_probe("stuck1", 4, 4, 1'b0, 4'b0111);
        mode4 = 2;
        run_probe("stuck0", 4, 4, 1'b0, 4'b1000);

        mode2 = 0; dly2 = 0;
        run_probe("ideal_s2", 2, 2, 1'b0, 4'b1111);

        // Reset clears the model history; start lands on the first edge after release.
        dly2 = 3;
        rst  = 1'b1;
        @(posedge clk);
        run_probe("dly3_s2", 2, 2, 1'b0, 4'b0110);

        mode4 = 0; dly4 = 1;
        run_probe("midstart", 4, 4, 1'b1, 4'b1111);

        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (14) @(negedge clk);
        check("pre_rst partial", 32'(res4[1:0]), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("midrst busy", 32'(busy4), 32'd0);
        check("midrst drive", 32'({a4, b4}), 32'd0);
        check("midrst result", 32'(res4), 32'd0);
        check("midrst ser", 32'({sv4, sd4, done4}), 32'd0);
        @(negedge clk);
        run_probe("after_rst", 4, 4, 1'b0, 4'b1111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
